// File: rtl/result_bcd_display_pkg.sv
// Shared types and constants for the result BCD display back end.
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits.
package result_bcd_display_pkg;

    localparam int RES_W = 9;
    localparam int MAG_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [11:0] bcd_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_bcd_display_if.sv
// Valid/ready handshake carrying the 9-bit result word.
// Build option: none.
interface result_bcd_display_if;
    import result_bcd_display_pkg::*;

    logic [RES_W-1:0] res_in;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_in,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_in,
        input  res_valid,
        output res_ready
    );

endinterface

// File: rtl/result_bcd_display_seg7_encode.sv
// BCD digit to active-low seven-segment code, bit order g..a.
// Build option: none.
module seg7_encode
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Decode one digit; non-BCD codes and blank show nothing.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_bcd_display.sv
// Result word to three seven-segment digits plus overflow LED.
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module result_bcd_display
    import result_bcd_display_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    result_bcd_display_if.slave  res,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic                 ovf_led,
    output logic                 disp_upd
);

    state_t           state_q;
    logic [MAG_W-1:0] mag_q;
    logic             flag_q;
    logic [11:0]      bcd_q;
    logic [2:0]       cnt_q;
    logic [6:0]       hex0_q;
    logic [6:0]       hex1_q;
    logic [6:0]       hex2_q;
    logic             ovf_q;
    logic             upd_q;

    logic [11:0]      bcd_d;
    logic [6:0]       seg0_d;
    logic [6:0]       seg1_d;
    logic [6:0]       seg2_d;
    logic             blank1_d;
    logic             blank2_d;

    assign bcd_d = bcd_adj(bcd_q);

`ifdef LEADING_ZERO_BLANK_EN
    assign blank2_d = (bcd_q[11:8] == 4'd0);
    assign blank1_d = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
    assign blank2_d = 1'b0;
    assign blank1_d = 1'b0;
`endif

    seg7_encode u_enc0 (
        .digit_i (bcd_q[3:0]),
        .blank_i (1'b0),
        .seg_o   (seg0_d)
    );

    seg7_encode u_enc1 (
        .digit_i (bcd_q[7:4]),
        .blank_i (blank1_d),
        .seg_o   (seg1_d)
    );

    seg7_encode u_enc2 (
        .digit_i (bcd_q[11:8]),
        .blank_i (blank2_d),
        .seg_o   (seg2_d)
    );

    // Capture, convert over eight shifts, then latch the display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            flag_q  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex0_q  <= SEG_BLANK;
            hex1_q  <= SEG_BLANK;
            hex2_q  <= SEG_BLANK;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (res.res_valid) begin
                        mag_q   <= res.res_in[MAG_W-1:0];
                        flag_q  <= res.res_in[RES_W-1];
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    {bcd_q, mag_q} <= {bcd_d[10:0], mag_q, 1'b0};
                    cnt_q          <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    hex0_q  <= seg0_d;
                    hex1_q  <= seg1_d;
                    hex2_q  <= seg2_d;
                    ovf_q   <= flag_q;
                    upd_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res.res_ready = (state_q == IDLE);
    assign hex0          = hex0_q;
    assign hex1          = hex1_q;
    assign hex2          = hex2_q;
    assign ovf_led       = ovf_q;
    assign disp_upd      = upd_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed self-checking bench for result_bcd_display.
// Expectations follow LEADING_ZERO_BLANK_EN when defined.
module tb_result_bcd_display;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ2 = BL;
    localparam logic [6:0] LZ1 = BL;
`else
    localparam logic [6:0] LZ2 = D0;
    localparam logic [6:0] LZ1 = D0;
`endif

    logic       clk;
    logic       rst_n;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic       ovf_led;
    logic       disp_upd;

    int checks;
    int errors;

    logic [21:0] prev_exp;

    result_bcd_display_if bus ();

    result_bcd_display dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .res      (bus),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .ovf_led  (ovf_led),
        .disp_upd (disp_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_in    = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({hex2, hex1, hex0, ovf_led} !== {BL, BL, BL, 1'b0}) begin
            errors++;
            $display("FAIL reset_disp got %b want %b",
                     {hex2, hex1, hex0, ovf_led}, {BL, BL, BL, 1'b0});
        end
        checks++;
        if (disp_upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_upd got %b want 0", disp_upd);
        end
        checks++;
        if (bus.res_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.res_ready);
        end
        prev_exp = {BL, BL, BL, 1'b0};
    endtask

    task automatic test_convert(input logic [8:0] w,
                                input logic [21:0] exp,
                                input string name);
        checks++;
        if (bus.res_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_pre got %b want 1", name, bus.res_ready);
        end
        bus.res_in    = w;
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        checks++;
        if (bus.res_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_busy got %b want 0", name, bus.res_ready);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (disp_upd !== 1'b0) begin
                errors++;
                $display("FAIL %s early_upd T+%0d got %b want 0",
                         name, i, disp_upd);
            end
        end
        checks++;
        if ({hex2, hex1, hex0, ovf_led} !== prev_exp) begin
            errors++;
            $display("FAIL %s held_T8 got %b want %b",
                     name, {hex2, hex1, hex0, ovf_led}, prev_exp);
        end
        tick();
        checks++;
        if ({hex2, hex1, hex0, ovf_led} !== exp) begin
            errors++;
            $display("FAIL %s disp got %b want %b",
                     name, {hex2, hex1, hex0, ovf_led}, exp);
        end
        checks++;
        if (disp_upd !== 1'b1) begin
            errors++;
            $display("FAIL %s upd_T9 got %b want 1", name, disp_upd);
        end
        checks++;
        if (bus.res_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_T9 got %b want 1", name, bus.res_ready);
        end
        tick();
        checks++;
        if (disp_upd !== 1'b0) begin
            errors++;
            $display("FAIL %s upd_T10 got %b want 0", name, disp_upd);
        end
        checks++;
        if ({hex2, hex1, hex0, ovf_led} !== exp) begin
            errors++;
            $display("FAIL %s hold got %b want %b",
                     name, {hex2, hex1, hex0, ovf_led}, exp);
        end
        prev_exp = exp;
    endtask

    task automatic test_back_to_back();
        bus.res_in    = 9'h0FF;
        bus.res_valid = 1'b1;
        tick();
        bus.res_in = 9'h007;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.res_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b ready T+%0d got %b want 0",
                         i - 1, bus.res_ready);
            end
            tick();
        end
        checks++;
        if (bus.res_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b ready T+8 got %b want 0", bus.res_ready);
        end
        tick();
        checks++;
        if ({hex2, hex1, hex0, ovf_led, disp_upd, bus.res_ready} !==
            {D2, D5, D5, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b first got %b want %b",
                     {hex2, hex1, hex0, ovf_led, disp_upd, bus.res_ready},
                     {D2, D5, D5, 1'b0, 1'b1, 1'b1});
        end
        tick();
        bus.res_valid = 1'b0;
        checks++;
        if (bus.res_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b accept_T10 ready got %b want 0",
                     bus.res_ready);
        end
        repeat (8) tick();
        checks++;
        if ({hex2, hex1, hex0, disp_upd} !== {D2, D5, D5, 1'b0}) begin
            errors++;
            $display("FAIL b2b T18 got %b want %b",
                     {hex2, hex1, hex0, disp_upd}, {D2, D5, D5, 1'b0});
        end
        tick();
        checks++;
        if ({hex2, hex1, hex0, ovf_led, disp_upd} !==
            {LZ2, LZ1, D7, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b second got %b want %b",
                     {hex2, hex1, hex0, ovf_led, disp_upd},
                     {LZ2, LZ1, D7, 1'b0, 1'b1});
        end
        tick();
        prev_exp = {LZ2, LZ1, D7, 1'b0};
    endtask

    task automatic test_reset_mid_conv();
        int upd_seen;
        bus.res_in    = 9'h17B;
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({hex2, hex1, hex0, ovf_led} !== {BL, BL, BL, 1'b0}) begin
            errors++;
            $display("FAIL midrst_disp got %b want %b",
                     {hex2, hex1, hex0, ovf_led}, {BL, BL, BL, 1'b0});
        end
        checks++;
        if (bus.res_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b want 1", bus.res_ready);
        end
        upd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (disp_upd === 1'b1) upd_seen++;
            tick();
        end
        checks++;
        if (upd_seen != 0 || {hex2, hex1, hex0} !== {BL, BL, BL}) begin
            errors++;
            $display("FAIL midrst_after upd_count %0d disp %b want 0 %b",
                     upd_seen, {hex2, hex1, hex0}, {BL, BL, BL});
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.res_in    = '0;
        bus.res_valid = 1'b0;
        prev_exp      = {BL, BL, BL, 1'b0};
        test_reset();
        test_convert(9'h0FF, {D2, D5, D5, 1'b0}, "w255");
        test_convert(9'h100, {LZ2, LZ1, D0, 1'b1}, "ovf0");
`ifdef LEADING_ZERO_BLANK_EN
        test_convert(9'h00A, {BL, D1, D0, 1'b0}, "w10");
`else
        test_convert(9'h00A, {D0, D1, D0, 1'b0}, "w10");
`endif
        test_convert(9'h009, {LZ2, LZ1, D9, 1'b0}, "w9");
        test_convert(9'h07B, {D1, D2, D3, 1'b0}, "w123");
        test_convert(9'h1C8, {D2, D0, D0, 1'b1}, "ovf200");
        test_back_to_back();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
